reg_bank: RTL and testbench

Parametrised register bank: the multi-entry, byte-addressable successor to the team's single 32-bit load register. It holds DEPTH words of WIDTH bits and has one write port with byte strobes, two read ports, an optional hard-wired zero register, optional write-to-read bypass, and a registered error flag. It is the storage stage for datapath blocks that need more than one operand register.

---
 rtl/reg_bank_pkg.sv | 43 ++++
 rtl/reg_bank_word.sv | 67 ++++++
 rtl/reg_bank.sv | 147 ++++++++++++++
 tb/tb_reg_bank.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bank_pkg
//  Description : Shared definitions for the reg_bank register file:
//                - address-width helper
//                - byte-strobed merge used by storage and bypass paths
//                - status record type (currently only the error bit)
//  Revision    : 1.0  initial release
// ============================================================================
package reg_bank_pkg;

    // Widest word the merge helper handles; callers cast to/from this width.
    localparam int MAX_WIDTH = 256;
    localparam int MAX_STRB  = MAX_WIDTH / 8;

    // Status bits captured by the bank; room left for future fields.
    typedef struct packed {
        logic err;
    } status_t;

    // Address width for a given register count.
    function automatic int calc_aw(input int depth);
        return $clog2(depth);
    endfunction

    // Returns old_v with each byte i replaced by new_v's byte i where strb[i]=1.
    function automatic logic [MAX_WIDTH-1:0] bytes_merge(
        input logic [MAX_WIDTH-1:0] old_v,
        input logic [MAX_WIDTH-1:0] new_v,
        input logic [MAX_STRB-1:0]  strb
    );
        logic [MAX_WIDTH-1:0] res;
        res = old_v;
        for (int i = 0; i < MAX_STRB; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_bank_word.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bank_word
//  Description : One WIDTH-bit storage word with asynchronous reset,
//                synchronous clear (priority over load) and byte-strobed load.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk      in   clock
//    rst      in   asynchronous active-high reset
//    clr_i    in   synchronous clear
//    load_i   in   load enable (already qualified as a legal write)
//    wstrb_i  in   byte strobes
//    wdata_i  in   write data
//    q_o      out  stored word
// ============================================================================
module reg_bank_word
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               load_i,
    input  logic [WIDTH/8-1:0] wstrb_i,
    input  logic [WIDTH-1:0]   wdata_i,
    output logic [WIDTH-1:0]   q_o
);

    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;

    always_comb begin
        word_d = word_q;
        if (clr_i) begin
            word_d = '0;
        end else if (load_i) begin
            word_d = WIDTH'(bytes_merge(MAX_WIDTH'(word_q), MAX_WIDTH'(wdata_i),
                                        MAX_STRB'(wstrb_i)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign q_o = word_q;

    // Storage behaviour properties.
    a_clr_zero : assert property (@(posedge clk) disable iff (rst)
        clr_i |=> (word_q == '0));

    a_load_merge : assert property (@(posedge clk) disable iff (rst)
        (!clr_i && load_i) |=> (word_q == WIDTH'(bytes_merge(
            MAX_WIDTH'($past(word_q)), MAX_WIDTH'($past(wdata_i)),
            MAX_STRB'($past(wstrb_i))))));

    a_hold : assert property (@(posedge clk) disable iff (rst)
        (!clr_i && !load_i) |=> $stable(word_q));

endmodule
`default_nettype wire

// File: rtl/reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bank
//  Description : DEPTH x WIDTH register bank, one byte-strobed write port,
//                two combinational read ports, optional hard-wired zero
//                register, optional write-to-read bypass, registered error
//                pulse on illegal writes.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk      in   clock
//    rst      in   asynchronous active-high reset
//    clr      in   synchronous clear of all registers
//    we       in   write enable
//    waddr    in   write address
//    wstrb    in   byte strobes
//    wdata    in   write data
//    raddr_a  in   read address A
//    rdata_a  out  read data A (combinational)
//    raddr_b  in   read address B
//    rdata_b  out  read data B (combinational)
//    err      out  one-cycle pulse after an illegal write
// ============================================================================
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b0,
    localparam int AW      = calc_aw(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [WIDTH/8-1:0] wstrb,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [AW-1:0]      raddr_a,
    output logic [WIDTH-1:0]   rdata_a,
    input  logic [AW-1:0]      raddr_b,
    output logic [WIDTH-1:0]   rdata_b,
    output logic               err
);

    // One extra bit so DEPTH itself is representable when it is a power of two.
    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    if ((WIDTH % 8) != 0 || WIDTH < 8 || WIDTH > MAX_WIDTH) begin : g_chk_width
        $error("reg_bank: WIDTH must be a multiple of 8 in [8, MAX_WIDTH]");
    end
    if (DEPTH < 2) begin : g_chk_depth
        $error("reg_bank: DEPTH must be at least 2");
    end

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] load;
    logic             waddr_ok;
    logic             wr_valid;
    logic [WIDTH-1:0] wr_old;
    logic [WIDTH-1:0] wr_merged;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;
    status_t          status_d;
    status_t          status_q;

    // Write decode. The zero register is never loaded, so its storage stays 0.
    always_comb begin
        waddr_ok = ({1'b0, waddr} < c_DEPTH) && !(ZERO_REG && (waddr == '0));
        wr_valid = we && waddr_ok;
        load     = '0;
        wr_old   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (waddr == AW'(k)) begin
                load[k] = wr_valid;
                wr_old  = regs[k];
            end
        end
        wr_merged = WIDTH'(bytes_merge(MAX_WIDTH'(wr_old), MAX_WIDTH'(wdata),
                                       MAX_STRB'(wstrb)));
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_word
        reg_bank_word #(
            .WIDTH (WIDTH)
        ) u_word (
            .clk     (clk),
            .rst     (rst),
            .clr_i   (clr),
            .load_i  (load[k]),
            .wstrb_i (wstrb),
            .wdata_i (wdata),
            .q_o     (regs[k])
        );
    end

    // Read multiplexers; out-of-range and zero-register addresses read 0.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (raddr_a == AW'(k)) begin
                rd_a = regs[k];
            end
            if (raddr_b == AW'(k)) begin
                rd_b = regs[k];
            end
        end
        if (ZERO_REG && (raddr_a == '0)) begin
            rd_a = '0;
        end
        if (ZERO_REG && (raddr_b == '0)) begin
            rd_b = '0;
        end

        // Bypass only forwards writes that will actually land at this edge.
        rdata_a = rd_a;
        rdata_b = rd_b;
        if (BYPASS && wr_valid && !clr) begin
            if (raddr_a == waddr) begin
                rdata_a = wr_merged;
            end
            if (raddr_b == waddr) begin
                rdata_b = wr_merged;
            end
        end
    end

    // Error flag: registered so err has no combinational input path.
    always_comb begin
        status_d     = '0;
        status_d.err = we && !waddr_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    assign err = status_q.err;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_bank
//  Description : Self-checking bench for reg_bank. Two instances share the
//                same stimulus: dut0 (DEPTH 8, no zero reg, no bypass) and
//                dut1 (DEPTH 6, zero reg, bypass). A per-instance array model
//                predicts every read and the err flag.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reg_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        we;
    logic [2:0]  waddr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [2:0]  raddr_a;
    logic [2:0]  raddr_b;
    logic [31:0] rda  [2];
    logic [31:0] rdb  [2];
    logic        errv [2];

    reg_bank #(.WIDTH(32), .DEPTH(8), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wstrb(wstrb),
        .wdata(wdata), .raddr_a(raddr_a), .rdata_a(rda[0]), .raddr_b(raddr_b),
        .rdata_b(rdb[0]), .err(errv[0])
    );

    reg_bank #(.WIDTH(32), .DEPTH(6), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wstrb(wstrb),
        .wdata(wdata), .raddr_a(raddr_a), .rdata_a(rda[1]), .raddr_b(raddr_b),
        .rdata_b(rdb[1]), .err(errv[1])
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] m [2][8];
    bit          exp_err [2];
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic int dep(input int k);
        return (k == 0) ? 8 : 6;
    endfunction

    function automatic bit has_zero(input int k);
        return (k == 1);
    endfunction

    function automatic bit has_byp(input int k);
        return (k == 1);
    endfunction

    function automatic bit legal(input int k, input int a);
        return (a < dep(k)) && !(has_zero(k) && a == 0);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~mask) | (n & mask);
    endfunction

    // Expected read data given the current inputs (bypass uses live inputs).
    function automatic logic [31:0] exp_read(input int k, input int a);
        logic [31:0] v;
        if (a >= dep(k) || (has_zero(k) && a == 0)) return 32'h0;
        v = m[k][a];
        if (has_byp(k) && !rst && we && !clr && legal(k, int'(waddr)) && int'(waddr) == a)
            v = merge(v, wdata, wstrb);
        return v;
    endfunction

    // Advance to the rising edge, update the model, settle.
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                exp_err[k] = 1'b0;
                for (int a = 0; a < 8; a++) m[k][a] = 32'h0;
            end else begin
                exp_err[k] = we && !legal(k, int'(waddr));
                if (clr) begin
                    for (int a = 0; a < 8; a++) m[k][a] = 32'h0;
                end else if (we && legal(k, int'(waddr))) begin
                    m[k][waddr] = merge(m[k][waddr], wdata, wstrb);
                end
            end
        end
        #1;
    endtask

    task automatic drive(input bit w, input int a, input logic [3:0] s,
                         input logic [31:0] d, input bit c, input int ra, input int rb);
        @(negedge clk);
        we = w; waddr = 3'(a); wstrb = s; wdata = d; clr = c;
        raddr_a = 3'(ra); raddr_b = 3'(rb);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        foreach (raddr_a[i]) ;
        for (int a = 0; a < 8; a += 3) begin
            raddr_a = 3'(a); raddr_b = 3'(7 - a);
            #1;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (rda[k] !== 32'h0 || rdb[k] !== 32'h0)
                    $display("FAIL reset_read dut%0d a=%0d: got %h/%h want 0", k, a, rda[k], rdb[k]);
                else n_pass++;
            end
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (errv[k] !== 1'b0) $display("FAIL reset_err dut%0d: got %b want 0", k, errv[k]);
            else n_pass++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_clear();
        drive(1, 3, 4'hF, 32'hDEAD_BEEF, 0, 3, 3);
        tick();
        drive(0, 0, 4'h0, 32'h0, 0, 3, 3);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (rda[k] !== 32'hDEAD_BEEF) $display("FAIL wr3 dut%0d: got %h want deadbeef", k, rda[k]);
            else n_pass++;
        end
        // Asynchronous reset: visible before any clock edge.
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (rda[k] !== 32'h0 || errv[k] !== 1'b0)
                $display("FAIL async_rst dut%0d: got %h err %b want 0 err 0", k, rda[k], errv[k]);
            else n_pass++;
        end
        tick();
        @(negedge clk);
        rst = 1'b0;
        // Clear wins over a write on the same edge.
        drive(1, 3, 4'hF, 32'hDEAD_BEEF, 0, 3, 3);
        tick();
        drive(1, 3, 4'hF, 32'h1234_5678, 1, 3, 3);
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (rda[k] !== 32'h0 || errv[k] !== 1'b0)
                $display("FAIL clr_wr dut%0d: got %h err %b want 0 err 0", k, rda[k], errv[k]);
            else n_pass++;
        end
    endtask

    task automatic test_strobes();
        drive(1, 2, 4'hF, 32'h1122_3344, 0, 2, 2);
        tick();
        drive(1, 2, 4'b0101, 32'hAABB_CCDD, 0, 2, 2);
        tick();
        drive(0, 0, 4'h0, 32'h0, 0, 2, 2);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (rda[k] !== 32'h11BB_33DD) $display("FAIL strobe dut%0d: got %h want 11bb33dd", k, rda[k]);
            else n_pass++;
        end
        drive(1, 2, 4'h0, 32'hFFFF_FFFF, 0, 2, 2);
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (rda[k] !== 32'h11BB_33DD || errv[k] !== 1'b0)
                $display("FAIL strobe0 dut%0d: got %h err %b want 11bb33dd err 0", k, rda[k], errv[k]);
            else n_pass++;
        end
    endtask

    task automatic test_dual_read();
        drive(1, 1, 4'hF, 32'h1, 0, 0, 0);
        tick();
        drive(1, 5, 4'hF, 32'h5, 0, 0, 0);
        tick();
        drive(0, 0, 4'h0, 32'h0, 0, 1, 5);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (rda[k] !== 32'h1 || rdb[k] !== 32'h5)
                $display("FAIL dual dut%0d: got %h/%h want 1/5", k, rda[k], rdb[k]);
            else n_pass++;
        end
        raddr_a = 3'd5;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (rda[k] !== 32'h5 || rdb[k] !== 32'h5)
                $display("FAIL dual_same dut%0d: got %h/%h want 5/5", k, rda[k], rdb[k]);
            else n_pass++;
        end
    endtask

    task automatic test_bypass();
        drive(1, 4, 4'hF, 32'h0101_0101, 0, 4, 4);
        tick();
        drive(1, 4, 4'hF, 32'hCAFE_0000, 0, 4, 4);
        n_checks++;
        if (rda[1] !== 32'hCAFE_0000) $display("FAIL bypass_on: got %h want cafe0000", rda[1]);
        else n_pass++;
        n_checks++;
        if (rda[0] !== 32'h0101_0101) $display("FAIL bypass_off_pre: got %h want 01010101", rda[0]);
        else n_pass++;
        tick();
        drive(0, 0, 4'h0, 32'h0, 0, 4, 4);
        n_checks++;
        if (rda[0] !== 32'hCAFE_0000) $display("FAIL bypass_off_post: got %h want cafe0000", rda[0]);
        else n_pass++;
        // Bypass must not forward under clear.
        drive(1, 4, 4'hF, 32'h7777_7777, 1, 4, 4);
        n_checks++;
        if (rda[1] !== 32'hCAFE_0000) $display("FAIL bypass_clr: got %h want cafe0000", rda[1]);
        else n_pass++;
        tick();
    endtask

    task automatic test_illegal();
        drive(1, 7, 4'hF, 32'h55AA_55AA, 0, 7, 7);
        tick();
        n_checks++;
        if (errv[1] !== 1'b1 || errv[0] !== 1'b0)
            $display("FAIL ill7_err: got %b/%b want 0/1", errv[0], errv[1]);
        else n_pass++;
        n_checks++;
        if (rdb[1] !== 32'h0 || rdb[0] !== 32'h55AA_55AA)
            $display("FAIL ill7_data: got %h/%h want 55aa55aa/0", rdb[0], rdb[1]);
        else n_pass++;
        drive(0, 0, 4'h0, 32'h0, 0, 0, 0);
        tick();
        n_checks++;
        if (errv[1] !== 1'b0) $display("FAIL ill7_pulse: got %b want 0", errv[1]);
        else n_pass++;
        drive(1, 0, 4'hF, 32'hFFFF_FFFF, 0, 0, 0);
        n_checks++;
        if (rda[1] !== 32'h0) $display("FAIL zero_byp: got %h want 0", rda[1]);
        else n_pass++;
        tick();
        n_checks++;
        if (rda[1] !== 32'h0 || errv[1] !== 1'b1)
            $display("FAIL zero_wr: got %h err %b want 0 err 1", rda[1], errv[1]);
        else n_pass++;
        drive(1, 6, 4'hF, 32'h1, 0, 0, 0);
        tick();
        drive(1, 7, 4'hF, 32'h2, 0, 0, 0);
        n_checks++;
        if (errv[1] !== 1'b1) $display("FAIL b2b_mid: got %b want 1", errv[1]);
        else n_pass++;
        tick();
        n_checks++;
        if (errv[1] !== 1'b1) $display("FAIL b2b_end: got %b want 1", errv[1]);
        else n_pass++;
        drive(0, 0, 4'h0, 32'h0, 0, 0, 0);
        tick();
        n_checks++;
        if (errv[1] !== 1'b0) $display("FAIL b2b_drop: got %b want 0", errv[1]);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 400; it++) begin
            if (it % 97 == 50) begin
                @(negedge clk);
                we = 1'b0; clr = 1'b0; rst = 1'b1;
                #1;
                for (int k = 0; k < 2; k++) begin
                    n_checks++;
                    if (rda[k] !== 32'h0 || rdb[k] !== 32'h0 || errv[k] !== 1'b0)
                        $display("FAIL rnd_rst dut%0d it=%0d: got %h/%h err %b want 0", k, it,
                                 rda[k], rdb[k], errv[k]);
                    else n_pass++;
                end
                tick();
                @(negedge clk);
                rst = 1'b0;
            end
            drive(($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)), 4'($urandom),
                  $urandom, ($urandom_range(0, 15) == 0),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (rda[k] !== exp_read(k, int'(raddr_a)) || rdb[k] !== exp_read(k, int'(raddr_b)))
                    $display("FAIL rnd_pre dut%0d it=%0d: got %h/%h want %h/%h", k, it, rda[k],
                             rdb[k], exp_read(k, int'(raddr_a)), exp_read(k, int'(raddr_b)));
                else n_pass++;
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (errv[k] !== exp_err[k] || rda[k] !== exp_read(k, int'(raddr_a)) ||
                    rdb[k] !== exp_read(k, int'(raddr_b)))
                    $display("FAIL rnd_post dut%0d it=%0d: got %h/%h err %b want %h/%h err %b",
                             k, it, rda[k], rdb[k], errv[k], exp_read(k, int'(raddr_a)),
                             exp_read(k, int'(raddr_b)), exp_err[k]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; we = 1'b0; waddr = '0; wstrb = '0; wdata = '0;
        raddr_a = '0; raddr_b = '0;
        for (int k = 0; k < 2; k++) begin
            exp_err[k] = 1'b0;
            for (int a = 0; a < 8; a++) m[k][a] = 32'h0;
        end
        test_reset();
        test_reset_clear();
        test_strobes();
        test_dual_read();
        test_bypass();
        test_illegal();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
